// File: rtl/core_pkg.sv
// Shared definitions for the integer core: datapath width, register index
// width and the hardwired-zero register index.
package core_pkg;

  localparam int DATA_W   = 32;
  localparam int NUM_REGS = 32;
  localparam int ADDR_W   = $clog2(NUM_REGS);

  typedef logic [DATA_W-1:0] word_t;
  typedef logic [ADDR_W-1:0] reg_idx_t;

  localparam reg_idx_t ZERO_REG = '0;

  // True when an index names x0, whose contents are architecturally zero.
  function automatic logic is_zero_reg(input reg_idx_t idx);
    return idx == ZERO_REG;
  endfunction

endpackage

// File: rtl/register_file_read_port.sv
// One combinational read port: selects a register by index and forces
// x0 to read as zero regardless of what the storage holds.
module rf_read_port #(
  parameter int DATA_W   = core_pkg::DATA_W,
  parameter int NUM_REGS = core_pkg::NUM_REGS,
  parameter int ADDR_W   = core_pkg::ADDR_W
) (
  input  logic [DATA_W-1:0] regs [NUM_REGS],
  input  logic [ADDR_W-1:0] index,
  output logic [DATA_W-1:0] data
);

  import core_pkg::*;

  // Zero-latency index mux with the x0 override.
  always_comb begin
    data = '0;
    if (index != '0) begin
      data = regs[index];
    end
  end

endmodule

// File: rtl/register_file.sv
// Integer register file: two asynchronous read ports for rs1/rs2 and one
// synchronous write port for rd writeback. x0 is hardwired to zero.
// There is deliberately no write-to-read bypass; a read of the register
// being written returns the old value until the clock edge, and any
// forwarding is the pipeline's job.
module register_file #(
  parameter int DATA_W   = core_pkg::DATA_W,
  parameter int NUM_REGS = core_pkg::NUM_REGS,
  parameter int ADDR_W   = core_pkg::ADDR_W
) (
  input  logic              clk,
  input  logic              nRST,
  input  logic              reg_write,
  input  logic [ADDR_W-1:0] write_index,
  input  logic [DATA_W-1:0] write_data,
  input  logic [ADDR_W-1:0] read_index1,
  input  logic [ADDR_W-1:0] read_index2,
  output logic [DATA_W-1:0] read_data1,
  output logic [DATA_W-1:0] read_data2
);

  import core_pkg::*;

  logic [DATA_W-1:0] regs [NUM_REGS];
  logic              write_en;

  // A write only lands when enabled and not aimed at x0, so regs[0]
  // keeps its reset value of zero forever.
  always_comb begin
    write_en = reg_write && (write_index != '0);
  end

  // Storage: cleared immediately on reset, single write port otherwise.
  always_ff @(posedge clk or negedge nRST) begin
    if (!nRST) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs[i] <= '0;
      end
    end else if (write_en) begin
      regs[write_index] <= write_data;
    end
  end

  rf_read_port #(
    .DATA_W  (DATA_W),
    .NUM_REGS(NUM_REGS),
    .ADDR_W  (ADDR_W)
  ) u_read_port1 (
    .regs (regs),
    .index(read_index1),
    .data (read_data1)
  );

  rf_read_port #(
    .DATA_W  (DATA_W),
    .NUM_REGS(NUM_REGS),
    .ADDR_W  (ADDR_W)
  ) u_read_port2 (
    .regs (regs),
    .index(read_index2),
    .data (read_data2)
  );

endmodule

// File: tb/tb_register_file.sv
// Directed bench for register_file with a read scoreboard.
module tb_register_file;

  import core_pkg::*;

  logic     clk;
  logic     nRST;
  logic     reg_write;
  reg_idx_t write_index;
  word_t    write_data;
  reg_idx_t read_index1;
  reg_idx_t read_index2;
  word_t    read_data1;
  word_t    read_data2;

  int checks = 0;
  int errors = 0;

  word_t model [NUM_REGS];

  typedef struct {
    string tag;
    logic  port;
    word_t exp;
  } sb_t;

  sb_t sb_q[$];

  register_file dut (
    .clk        (clk),
    .nRST       (nRST),
    .reg_write  (reg_write),
    .write_index(write_index),
    .write_data (write_data),
    .read_index1(read_index1),
    .read_index2(read_index2),
    .read_data1 (read_data1),
    .read_data2 (read_data2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic expect_rd(input string tag, input logic port, input word_t exp);
    sb_t e;
    e.tag  = tag;
    e.port = port;
    e.exp  = exp;
    sb_q.push_back(e);
  endtask

  task automatic drain();
    sb_t   e;
    word_t obs;
    while (sb_q.size() > 0) begin
      e   = sb_q.pop_front();
      obs = e.port ? read_data2 : read_data1;
      checks++;
      assert (obs === e.exp) else begin
        errors++;
        $error("FAIL %s observed %h expected %h", e.tag, obs, e.exp);
      end
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < NUM_REGS; i++) model[i] = '0;
  endtask

  task automatic do_write(input logic we, input reg_idx_t idx, input word_t data);
    @(negedge clk);
    reg_write   = we;
    write_index = idx;
    write_data  = data;
    @(posedge clk);
    #1;
    if (we && idx != 0) model[idx] = data;
    reg_write = 1'b0;
  endtask

  task automatic read_both(input string tag, input reg_idx_t i1, input reg_idx_t i2);
    read_index1 = i1;
    read_index2 = i2;
    #1;
    expect_rd({tag, "_p1"}, 1'b0, model[i1]);
    expect_rd({tag, "_p2"}, 1'b1, model[i2]);
    drain();
  endtask

  initial begin
    word_t    rnd;
    reg_idx_t a;
    reg_idx_t b;

    nRST        = 1'b1;
    reg_write   = 1'b0;
    write_index = '0;
    write_data  = '0;
    read_index1 = 5'd3;
    read_index2 = 5'd7;
    model_reset();

    // Reset asserted mid-cycle: outputs are zero at once and after release.
    #3;
    nRST = 1'b0;
    #1;
    expect_rd("rst_now_p1", 1'b0, 32'h0);
    expect_rd("rst_now_p2", 1'b1, 32'h0);
    drain();
    @(negedge clk);
    nRST = 1'b1;
    @(posedge clk);
    #1;
    expect_rd("rst_after_p1", 1'b0, 32'h0);
    expect_rd("rst_after_p2", 1'b1, 32'h0);
    drain();

    // Disabled write leaves x1 untouched over several clocks.
    @(negedge clk);
    reg_write   = 1'b0;
    write_index = 5'd1;
    write_data  = 32'hAAAAAAAA;
    repeat (3) @(posedge clk);
    #1;
    read_index1 = 5'd1;
    #1;
    expect_rd("no_write", 1'b0, 32'h0);
    drain();

    // Write then overwrite x1.
    do_write(1'b1, 5'd1, 32'hAAAAAAAA);
    read_index2 = 5'd1;
    #1;
    expect_rd("write_x1", 1'b1, 32'hAAAAAAAA);
    drain();
    do_write(1'b1, 5'd1, 32'hAAAAAAAF);
    read_index1 = 5'd1;
    #1;
    expect_rd("overwrite_x1", 1'b0, 32'hAAAAAAAF);
    drain();

    // Distinct patterns to power-of-two indices, read in pairs.
    do_write(1'b1, 5'd2,  32'hFACEAAAA);
    do_write(1'b1, 5'd4,  32'hAAAAFACE);
    do_write(1'b1, 5'd8,  32'hAAFACEAA);
    do_write(1'b1, 5'd16, 32'hFAAAAACE);
    read_index1 = 5'd2;
    read_index2 = 5'd4;
    #1;
    expect_rd("x2", 1'b0, 32'hFACEAAAA);
    expect_rd("x4", 1'b1, 32'hAAAAFACE);
    drain();
    read_index1 = 5'd8;
    read_index2 = 5'd16;
    #1;
    expect_rd("x8",  1'b0, 32'hAAFACEAA);
    expect_rd("x16", 1'b1, 32'hFAAAAACE);
    drain();

    // Writes to x0 are discarded.
    do_write(1'b1, 5'd0, 32'hDEADBEEF);
    read_index1 = 5'd0;
    read_index2 = 5'd0;
    #1;
    expect_rd("x0_p1", 1'b0, 32'h0);
    expect_rd("x0_p2", 1'b1, 32'h0);
    drain();

    // Read-during-write on x5: old value before the edge, new after.
    do_write(1'b1, 5'd5, 32'h12345678);
    @(negedge clk);
    reg_write   = 1'b1;
    write_index = 5'd5;
    write_data  = 32'hCAFEF00D;
    read_index1 = 5'd5;
    read_index2 = 5'd5;
    #1;
    expect_rd("rdw_old_p1", 1'b0, 32'h12345678);
    expect_rd("rdw_old_p2", 1'b1, 32'h12345678);
    drain();
    @(posedge clk);
    #1;
    reg_write = 1'b0;
    model[5]  = 32'hCAFEF00D;
    expect_rd("rdw_new_p1", 1'b0, 32'hCAFEF00D);
    expect_rd("rdw_new_p2", 1'b1, 32'hCAFEF00D);
    drain();

    // Random fill of every register, then paired readback.
    for (int i = 0; i < NUM_REGS; i++) begin
      rnd = $urandom;
      do_write(1'b1, reg_idx_t'(i), rnd);
    end
    for (int i = 0; i < NUM_REGS; i++) begin
      a = reg_idx_t'(i);
      b = reg_idx_t'(NUM_REGS - 1 - i);
      read_both("sweep", a, b);
    end

    // Reset mid-operation discards contents.
    @(negedge clk);
    #2;
    nRST = 1'b0;
    model_reset();
    read_index1 = 5'd5;
    read_index2 = 5'd31;
    #1;
    expect_rd("rst_x5",  1'b0, 32'h0);
    expect_rd("rst_x31", 1'b1, 32'h0);
    drain();
    @(negedge clk);
    nRST = 1'b1;
    read_both("post_rst", 5'd1, 5'd16);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
